// File: rtl/conv_tile_accumulator.sv
// Channel-serial accumulate, pool and ReLU stage placed behind a tile convolution kernel.
// Sums N_CHANNELS partial tiles onto a per-kernel bias with saturation; one result per kernel.

module conv_tile_accumulator #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_WIDTH = 16,
  parameter int unsigned TILE       = 4,
  parameter int unsigned N_CHANNELS = 3,
  parameter int unsigned N_KERNELS  = 64,
  parameter int unsigned POOL_MODE  = 1,
  parameter int unsigned RELU_EN    = 1,
  localparam int unsigned OUT_COUNT = (POOL_MODE == 0) ? TILE : 1,
  localparam int unsigned KW        = $clog2(N_KERNELS) + 1
) (
  input  logic                                  clock_i,
  input  logic                                  reset_ni,
  input  logic                                  clear_i,
  input  logic [N_KERNELS-1:0][DATA_WIDTH-1:0]  bias_i,
  input  logic                                  partial_valid_i,
  output logic                                  partial_ready_o,
  input  logic [TILE-1:0][DATA_WIDTH-1:0]       partial_i,
  output logic                                  data_valid_o,
  input  logic                                  data_ready_i,
  output logic [OUT_COUNT-1:0][DATA_WIDTH-1:0]  data_o,
  output logic [KW-1:0]                         kernel_o,
  output logic                                  last_o,
  output logic                                  overflow_o
);

  localparam int unsigned LOG2_TILE = $clog2(TILE);
  localparam int unsigned KIW       = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;
  localparam int unsigned CW        = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int unsigned SW        = DATA_WIDTH + LOG2_TILE;
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  if ((TILE == 0) || ((TILE & (TILE - 1)) != 0)) begin : g_bad_tile
    $error("TILE must be a nonzero power of 2");
  end
  if ((N_CHANNELS == 0) || (POOL_MODE > 2)) begin : g_bad_cfg
    $error("N_CHANNELS must be >= 1 and POOL_MODE in 0..2");
  end
  if (FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_frac
    $error("FRAC_WIDTH must be below DATA_WIDTH");
  end

  typedef enum logic [1:0] {StAccum, StPost, StOutput} state_e;

  state_e                              state_q;
  logic [CW-1:0]                       channel_q;
  logic [KW-1:0]                       kernel_q;
  logic signed [DATA_WIDTH-1:0]        acc_q [TILE];
  logic [OUT_COUNT-1:0][DATA_WIDTH-1:0] data_q;
  logic                                valid_q;
  logic                                last_q;
  logic                                overflow_q;
  logic [KW-1:0]                       kernel_out_q;

  logic [DATA_WIDTH-1:0]               base [TILE];
  logic [DATA_WIDTH:0]                 sum_w [TILE];
  logic [DATA_WIDTH-1:0]               acc_d [TILE];
  logic                                sat_any;
  logic [OUT_COUNT-1:0][DATA_WIDTH-1:0] post_d;

  // One extra sign bit exposes overflow: top two bits differ exactly when the sum left range.
  always_comb begin
    sat_any = 1'b0;
    for (int i = 0; i < TILE; i++) begin
      base[i]  = (channel_q == '0) ? bias_i[kernel_q[KIW-1:0]] : acc_q[i];
      sum_w[i] = {base[i][DATA_WIDTH-1], base[i]} +
                 {partial_i[i][DATA_WIDTH-1], partial_i[i]};
      if (sum_w[i][DATA_WIDTH] != sum_w[i][DATA_WIDTH-1]) begin
        acc_d[i] = sum_w[i][DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        sat_any  = 1'b1;
      end else begin
        acc_d[i] = sum_w[i][DATA_WIDTH-1:0];
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] v);
    return ((RELU_EN != 0) && v[DATA_WIDTH-1]) ? '0 : v;
  endfunction

  if (POOL_MODE == 0) begin : g_pool_none
    always_comb begin
      for (int i = 0; i < TILE; i++) post_d[i] = relu(acc_q[i]);
    end
  end else if (POOL_MODE == 1) begin : g_pool_max
    logic signed [DATA_WIDTH-1:0] max_v;
    always_comb begin
      max_v = acc_q[0];
      for (int i = 1; i < TILE; i++) begin
        if (acc_q[i] > max_v) max_v = acc_q[i];
      end
      post_d[0] = relu(max_v);
    end
  end else begin : g_pool_avg
    // Widened sum cannot overflow; arithmetic shift floors toward -infinity.
    logic signed [SW-1:0] sum_v;
    always_comb begin
      sum_v = '0;
      for (int i = 0; i < TILE; i++) sum_v = sum_v + SW'(acc_q[i]);
      post_d[0] = relu(DATA_WIDTH'(sum_v >>> LOG2_TILE));
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= StAccum;
      channel_q    <= '0;
      kernel_q     <= '0;
      for (int i = 0; i < TILE; i++) acc_q[i] <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      kernel_out_q <= '0;
      last_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (clear_i) begin
      state_q      <= StAccum;
      channel_q    <= '0;
      kernel_q     <= '0;
      for (int i = 0; i < TILE; i++) acc_q[i] <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      kernel_out_q <= '0;
      last_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (partial_valid_i) begin
            for (int i = 0; i < TILE; i++) acc_q[i] <= acc_d[i];
            if (sat_any) overflow_q <= 1'b1;
            if (channel_q == CW'(N_CHANNELS - 1)) begin
              channel_q <= '0;
              state_q   <= StPost;
            end else begin
              channel_q <= channel_q + CW'(1);
            end
          end
        end
        StPost: begin
          data_q       <= post_d;
          valid_q      <= 1'b1;
          kernel_out_q <= kernel_q;
          last_q       <= (kernel_q == KW'(N_KERNELS - 1));
          state_q      <= StOutput;
        end
        StOutput: begin
          if (data_ready_i) begin
            valid_q  <= 1'b0;
            kernel_q <= (kernel_q == KW'(N_KERNELS - 1)) ? '0 : kernel_q + KW'(1);
            state_q  <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

  assign partial_ready_o = (state_q == StAccum);
  assign data_valid_o    = valid_q;
  assign data_o          = data_q;
  assign kernel_o        = kernel_out_q;
  assign last_o          = last_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_conv_tile_accumulator.sv
// Bench for conv_tile_accumulator: three configurations (max/ReLU, avg N_CHANNELS=1, none/ReLU)
// driven with directed and random tiles and compared against an arithmetic reference model.

module tb_conv_tile_accumulator;

  localparam int DW = 32;
  localparam int T  = 4;
  localparam int NK = 4;
  localparam int KW = 3;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, clear, dready;
  logic [NK-1:0][DW-1:0]  bias;
  logic [T-1:0][DW-1:0]   partial;
  logic [2:0]             pv;
  wire  [2:0]             pr, dv, lst, ovf;
  wire  [KW-1:0]          kern_a, kern_b, kern_c;
  wire  [0:0][DW-1:0]     data_a, data_b;
  wire  [T-1:0][DW-1:0]   data_c;

  int     checks = 0;
  int     errors = 0;
  longint tl [3][T];
  longint m_res [T];
  bit     m_ovf;
  int     kexp [3];
  bit     ovf_exp [3];

  conv_tile_accumulator #(.DATA_WIDTH(DW), .FRAC_WIDTH(16), .TILE(T), .N_CHANNELS(3),
    .N_KERNELS(NK), .POOL_MODE(1), .RELU_EN(1)) dut_a (
    .clock_i(clk), .reset_ni(rst_n), .clear_i(clear), .bias_i(bias),
    .partial_valid_i(pv[0]), .partial_ready_o(pr[0]), .partial_i(partial),
    .data_valid_o(dv[0]), .data_ready_i(dready), .data_o(data_a), .kernel_o(kern_a),
    .last_o(lst[0]), .overflow_o(ovf[0]));

  conv_tile_accumulator #(.DATA_WIDTH(DW), .FRAC_WIDTH(16), .TILE(T), .N_CHANNELS(1),
    .N_KERNELS(NK), .POOL_MODE(2), .RELU_EN(0)) dut_b (
    .clock_i(clk), .reset_ni(rst_n), .clear_i(clear), .bias_i(bias),
    .partial_valid_i(pv[1]), .partial_ready_o(pr[1]), .partial_i(partial),
    .data_valid_o(dv[1]), .data_ready_i(dready), .data_o(data_b), .kernel_o(kern_b),
    .last_o(lst[1]), .overflow_o(ovf[1]));

  conv_tile_accumulator #(.DATA_WIDTH(DW), .FRAC_WIDTH(16), .TILE(T), .N_CHANNELS(3),
    .N_KERNELS(NK), .POOL_MODE(0), .RELU_EN(1)) dut_c (
    .clock_i(clk), .reset_ni(rst_n), .clear_i(clear), .bias_i(bias),
    .partial_valid_i(pv[2]), .partial_ready_o(pr[2]), .partial_i(partial),
    .data_valid_o(dv[2]), .data_ready_i(dready), .data_o(data_c), .kernel_o(kern_c),
    .last_o(lst[2]), .overflow_o(ovf[2]));

  function automatic int nch(input int inst);
    return (inst == 1) ? 1 : 3;
  endfunction

  function automatic int pool_of(input int inst);
    return (inst == 0) ? 1 : ((inst == 1) ? 2 : 0);
  endfunction

  function automatic bit relu_of(input int inst);
    return inst != 1;
  endfunction

  function automatic logic [DW-1:0] dout(input int inst, input int idx);
    case (inst)
      0:       return data_a[0];
      1:       return data_b[0];
      default: return data_c[idx];
    endcase
  endfunction

  function automatic logic [KW-1:0] kout(input int inst);
    case (inst)
      0:       return kern_a;
      1:       return kern_b;
      default: return kern_c;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: clamp after every addition, then pool and ReLU on plain integers.
  function automatic void model(input int inst, input longint b);
    longint acc [T];
    longint s, mx, sum, q;
    m_ovf = 1'b0;
    for (int i = 0; i < T; i++) begin
      s = b;
      for (int c = 0; c < nch(inst); c++) begin
        s = s + tl[c][i];
        if (s > MAXV) begin
          s = MAXV; m_ovf = 1'b1;
        end else if (s < MINV) begin
          s = MINV; m_ovf = 1'b1;
        end
      end
      acc[i] = s;
    end
    for (int i = 0; i < T; i++) m_res[i] = 0;
    case (pool_of(inst))
      0: for (int i = 0; i < T; i++) m_res[i] = acc[i];
      1: begin
        mx = acc[0];
        for (int i = 1; i < T; i++) if (acc[i] > mx) mx = acc[i];
        m_res[0] = mx;
      end
      default: begin
        sum = 0;
        for (int i = 0; i < T; i++) sum = sum + acc[i];
        q = sum / T;
        if ((q * T != sum) && (sum < 0)) q = q - 1;
        m_res[0] = q;
      end
    endcase
    if (relu_of(inst)) for (int i = 0; i < T; i++) if (m_res[i] < 0) m_res[i] = 0;
  endfunction

  function automatic longint rnd();
    logic [31:0] u;
    int sel;
    u = $urandom;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       return longint'($signed(u));
      1:       return u[0] ? MAXV : MINV;
      default: return longint'($urandom_range(0, 4000)) - 2000;
    endcase
  endfunction

  task automatic fill_random();
    for (int c = 0; c < 3; c++) for (int i = 0; i < T; i++) tl[c][i] = rnd();
    for (int k = 0; k < NK; k++) bias[k] = DW'(rnd());
  endtask

  task automatic set_tile(input int c, input longint a0, input longint a1,
                          input longint a2, input longint a3);
    tl[c][0] = a0; tl[c][1] = a1; tl[c][2] = a2; tl[c][3] = a3;
  endtask

  task automatic send_tile(input int inst, input int c);
    int n;
    @(negedge clk);
    for (int i = 0; i < T; i++) partial[i] = tl[c][i][DW-1:0];
    pv[inst] = 1'b1;
    n = 0;
    while (pr[inst] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept%0d", inst), 64'(pr[inst]), 64'd1);
    @(posedge clk);
    #1;
    pv[inst] = 1'b0;
  endtask

  // Returns on the falling edge where data_valid_o is first seen high.
  task automatic run_kernel(input int inst, input bit check_lat);
    int n, k;
    k = kexp[inst];
    model(inst, longint'($signed(bias[k])));
    for (int c = 0; c < nch(inst); c++) send_tile(inst, c);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dv[inst] !== 1'b1 && n < 20);
    ovf_exp[inst] = ovf_exp[inst] | m_ovf;
    chk($sformatf("valid%0d_k%0d", inst, k), 64'(dv[inst]), 64'd1);
    if (check_lat) chk($sformatf("latency%0d", inst), 64'(n), 64'd2);
    for (int i = 0; i < ((pool_of(inst) == 0) ? T : 1); i++)
      chk($sformatf("data%0d_k%0d_%0d", inst, k, i), 64'(dout(inst, i)),
          64'(m_res[i][DW-1:0]));
    chk($sformatf("kernel%0d", inst), 64'(kout(inst)), 64'(k));
    chk($sformatf("last%0d_k%0d", inst, k), 64'(lst[inst]), 64'(k == NK - 1));
    chk($sformatf("ovf%0d_k%0d", inst, k), 64'(ovf[inst]), 64'(ovf_exp[inst]));
    kexp[inst] = (k + 1) % NK;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; dready = 1'b1; pv = '0; bias = '0; partial = '0;
    for (int i = 0; i < 3; i++) begin
      kexp[i] = 0; ovf_exp[i] = 1'b0;
    end
    #1;
    chk("rst_ready", 64'(pr), 64'h7);
    chk("rst_valid", 64'(dv), 64'h0);
    chk("rst_last", 64'(lst), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    chk("rst_kernel", 64'({kern_a, kern_b, kern_c}), 64'h0);
    chk("rst_data", 64'({data_a, data_b}), 64'h0);
    chk("rst_data_c", 64'(data_c == '0), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Q16.16 three-channel accumulate on max and no-pool instances
    bias[0] = 32'h0001_0000;
    for (int c = 0; c < 3; c++) set_tile(c, 64'h10000, 64'h20000, -64'sh8000, 0);
    run_kernel(0, 1'b1);
    chk("t1_max", 64'(data_a[0]), 64'h0007_0000);
    chk("t1_kernel", 64'(kern_a), 64'd0);
    chk("t1_last", 64'(lst[0]), 64'd0);
    run_kernel(2, 1'b1);
    chk("t1_c0", 64'(data_c[0]), 64'h0004_0000);
    chk("t1_c2_relu", 64'(data_c[2]), 64'd0);

    // Average floors toward -infinity, N_CHANNELS=1
    bias = '0;
    set_tile(0, -1, -2, -3, -4);
    run_kernel(1, 1'b1);
    chk("avg_floor", 64'(data_b[0]), 64'hFFFF_FFFD);

    // Saturation and sticky overflow
    set_tile(0, 5, -5, MAXV, -1);
    set_tile(1, 0, 0, 1, 0);
    set_tile(2, 0, 0, 1, 0);
    run_kernel(2, 1'b0);
    chk("sat_c0", 64'(data_c[0]), 64'd5);
    chk("sat_c2", 64'(data_c[2]), 64'h7FFF_FFFF);
    chk("sat_ovf", 64'(ovf[2]), 64'd1);
    for (int c = 0; c < 3; c++) set_tile(c, 1, 2, 3, 4);
    run_kernel(2, 1'b0);
    chk("ovf_sticky", 64'(ovf[2]), 64'd1);

    // Back-pressure on kernel 1 of the max instance
    fill_random();
    dready = 1'b0;
    run_kernel(0, 1'b1);
    for (int i = 0; i < T; i++) partial[i] = DW'($urandom);
    pv[0] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("bp_data%0d", j), 64'(data_a[0]), 64'(m_res[0][DW-1:0]));
      chk($sformatf("bp_kernel%0d", j), 64'(kern_a), 64'd1);
      chk($sformatf("bp_ready%0d", j), 64'(pr[0]), 64'd0);
      chk($sformatf("bp_valid%0d", j), 64'(dv[0]), 64'd1);
    end
    pv[0] = 1'b0;
    dready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(pr[0]), 64'd1);
    chk("bp_release_valid", 64'(dv[0]), 64'd0);

    // Random kernels; the max instance wraps through kernels 2,3,0,1,2,3
    for (int j = 0; j < 6; j++) begin
      fill_random();
      run_kernel(0, 1'b1);
    end
    for (int j = 0; j < 4; j++) begin
      fill_random();
      run_kernel(1, 1'b1);
    end
    for (int j = 0; j < 3; j++) begin
      fill_random();
      run_kernel(2, 1'b1);
    end

    // Clear mid-tile drops the partial accumulation and the tile offered during clear
    fill_random();
    send_tile(0, 0);
    send_tile(0, 1);
    @(negedge clk);
    clear = 1'b1;
    pv[0] = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    pv[0] = 1'b0;
    chk("clr_ready", 64'(pr), 64'h7);
    chk("clr_valid", 64'(dv), 64'h0);
    chk("clr_ovf", 64'(ovf), 64'h0);
    chk("clr_kernel", 64'(kern_a), 64'd0);
    for (int i = 0; i < 3; i++) begin
      kexp[i] = 0; ovf_exp[i] = 1'b0;
    end
    fill_random();
    run_kernel(0, 1'b1);
    fill_random();
    bias[1] = 32'h0010_0000;
    for (int c = 0; c < 3; c++) set_tile(c, 7, 9, -3, 1);
    run_kernel(0, 1'b1);

    // Asynchronous reset between clock edges, mid-tile
    fill_random();
    send_tile(0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(pr), 64'h7);
    chk("arst_valid", 64'(dv), 64'h0);
    chk("arst_last", 64'(lst), 64'h0);
    chk("arst_ovf", 64'(ovf), 64'h0);
    chk("arst_kernel", 64'(kern_a), 64'd0);
    chk("arst_data", 64'(data_a[0]), 64'd0);
    chk("arst_data_c", 64'(data_c == '0), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      kexp[i] = 0; ovf_exp[i] = 1'b0;
    end
    fill_random();
    run_kernel(0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
